// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data load/store) for one shared memory port.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive lost IDLE decisions.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_D  = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  wait_cnt_d;
  logic        grant_if_d;
  logic        grant_d_d;

  logic        m_valid_q;
  logic        m_we_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic [3:0]  m_be_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        if_done_q;
  logic        d_done_q;

  // Grant decision is only meaningful in IDLE; wait_cnt counts fetch losses there.
  always_comb begin
    grant_if_d = 1'b0;
    grant_d_d  = 1'b0;
    wait_cnt_d = wait_cnt_q;
    if (state_q == IDLE) begin
      if (if_req && d_req) begin
        if (wait_cnt_q >= LIMIT) begin
          grant_if_d = 1'b1;
        end else begin
          grant_d_d  = 1'b1;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end else if (d_req) begin
        grant_d_d = 1'b1;
      end else if (if_req) begin
        grant_if_d = 1'b1;
      end
      if (grant_if_d) begin
        wait_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      m_valid_q  <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= 32'd0;
      m_wdata_q  <= 32'd0;
      m_be_q     <= 4'd0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_cnt_q <= wait_cnt_d;
          if (grant_if_d) begin
            state_q   <= SERVE_IF;
            m_valid_q <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= if_addr;
            m_wdata_q <= 32'd0;
            m_be_q    <= 4'hF;
          end else if (grant_d_d) begin
            state_q   <= SERVE_D;
            m_valid_q <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            m_be_q    <= d_we ? d_be : 4'hF;
          end
        end
        SERVE_IF: begin
          if (m_ready) begin
            if_rdata_q <= m_rdata;
            m_valid_q  <= 1'b0;
            if_done_q  <= 1'b1;
            state_q    <= DONE;
          end
        end
        SERVE_D: begin
          if (m_ready) begin
            // Stores leave the last loaded word visible on d_rdata.
            if (!m_we_q) begin
              d_rdata_q <= m_rdata;
            end
            m_valid_q <= 1'b0;
            d_done_q  <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if_done_q <= 1'b0;
          d_done_q  <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_valid  = m_valid_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_be     = m_be_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_done  = if_done_q;
  assign d_done   = d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected transactions queued at request time,
// checked when the shared port command appears and when the done pulse fires.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_b;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic [31:0] m_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .m_valid  (m_valid),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_if_rdata = 32'd0;
  logic [31:0] exp_d_rdata  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic push_if(input logic [31:0] addr, input logic [31:0] rdata);
    exp_t e;
    e.is_if = 1'b1; e.we = 1'b0; e.addr = addr; e.wdata = 32'd0; e.be = 4'hF; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] rdata);
    exp_t e;
    e.is_if = 1'b0; e.we = we; e.addr = addr; e.wdata = wdata;
    e.be = we ? be : 4'hF; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Waits for the next command, holds m_ready low for 'delay' cycles, completes it,
  // checks the done pulse, optionally drops requests, then checks the following IDLE cycle.
  task automatic serve(input int delay, input bit drop_if, input bit drop_d, output int waited);
    exp_t e;
    int   w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_valid && w < 20);
    waited = w;
    chk1("cmd_valid_seen", m_valid, 1'b1);
    if (!m_valid) return;
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    m_ready = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      if (i > 0) @(negedge clk);
      chk1("cmd_valid_hold", m_valid, 1'b1);
      chk1("cmd_we", m_we, e.we);
      chk("cmd_addr", m_addr, e.addr);
      chk("cmd_wdata", m_wdata, e.wdata);
      chk("cmd_be", 32'(m_be), 32'(e.be));
      chk1("no_done_in_serve", if_done | d_done, 1'b0);
    end
    m_ready = 1'b1;
    m_rdata = e.rdata;
    @(negedge clk);
    m_ready = 1'b0;
    m_rdata = $urandom;
    if (e.is_if) exp_if_rdata = e.rdata;
    else if (!e.we) exp_d_rdata = e.rdata;
    chk1("if_done_pulse", if_done, e.is_if);
    chk1("d_done_pulse", d_done, !e.is_if);
    chk1("m_valid_in_done", m_valid, 1'b0);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    if (drop_if) if_req = 1'b0;
    if (drop_d) d_req = 1'b0;
    @(negedge clk);
    chk1("done_one_cycle", if_done | d_done, 1'b0);
    chk1("m_valid_in_idle", m_valid, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_we"}, 32'(m_we), 32'd0);
    chk({tag, "_m_addr"}, m_addr, 32'd0);
    chk({tag, "_m_wdata"}, m_wdata, 32'd0);
    chk({tag, "_m_be"}, 32'(m_be), 32'd0);
    chk({tag, "_dones"}, 32'({if_done, d_done}), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst_b = 1'b0; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0; m_ready = 1'b0; m_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_b = 1'b1;
    @(negedge clk);
    chk1("idle_no_cmd", m_valid, 1'b0);

    // Fetch only, zero wait state.
    if_req = 1'b1; if_addr = 32'h40;
    push_if(32'h40, 32'h2002000A);
    serve(0, 1'b1, 1'b0, w);
    chk("fetch_latency", w, 1);

    // Store with three wait cycles; d_rdata must stay at its previous value.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    push_d(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 32'h5555AAAA);
    serve(3, 1'b0, 1'b1, w);
    chk("store_latency", w, 1);

    // Load and fetch requested together: data first, then fetch after one IDLE cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0; d_be = 4'h0;
    if_req = 1'b1; if_addr = 32'h44;
    push_d(1'b0, 32'h200, 32'h0, 4'h0, 32'h12345678);
    push_if(32'h44, 32'h0BADF00D);
    serve(0, 1'b0, 1'b1, w);
    chk("load_first_latency", w, 1);
    serve(1, 1'b1, 1'b0, w);
    chk("fetch_after_idle", w, 1);

    // Both held continuously: four data grants then one fetch, twice.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) push_if(32'h80, 32'hF000_0000 + 32'(k));
      else push_d(1'b0, 32'h300, 32'h0, 4'h0, 32'hD000_0000 + 32'(k));
      serve(k % 2, 1'b0, 1'b0, w);
      chk("starve_gap", w, 1);
      chk1("wait_cnt_bound", dut.wait_cnt_q <= 4'd4, 1'b1);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk1("quiet_idle", m_valid, 1'b0);

    // Reset during a stalled fetch: abandoned without done, then retried normally.
    if_req = 1'b1; if_addr = 32'h500;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_valid && w < 20);
    chk1("rst_case_cmd", m_valid, 1'b1);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    chk1("rst_no_if_done", if_done, 1'b0);
    exp_q.delete();
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;
    rst_b = 1'b1;
    push_if(32'h500, 32'hCAFEF00D);
    serve(1, 1'b1, 1'b0, w);
    chk("post_rst_latency", w, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
